// File: rtl/vram_plotter_if.sv
// Command, framebuffer-port and readback signal bundle for vram_plotter.
// The master side issues commands and models the RAM; the slave side is the plotter.
interface vram_plotter_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [8:0]  cmd_x;
    logic [7:0]  cmd_y;
    logic [1:0]  cmd_color;
    logic [13:0] mem_address;
    logic [7:0]  mem_rdata;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic [1:0]  rd_data;
    logic        rd_valid;

    modport master (
        output cmd_valid, cmd_op, cmd_x, cmd_y, cmd_color, mem_rdata,
        input  cmd_ready, mem_address, mem_wdata, mem_we, rd_data, rd_valid
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_x, cmd_y, cmd_color, mem_rdata,
        output cmd_ready, mem_address, mem_wdata, mem_we, rd_data, rd_valid
    );
endinterface

// File: rtl/vram_plotter.sv
// Write-side master for the 2-bpp packed 320x200 framebuffer: plot, xor-plot, clear.
// Optional pixel readback (op 11) is enabled by defining VRAM_PLOTTER_READBACK_EN.
module vram_plotter #(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 200,
    parameter int STRIDE = 80
) (
    input  logic          clock,
    input  logic          reset,
    vram_plotter_if.slave bus
);

    localparam logic [8:0]  X_LIMIT   = 9'(WIDTH);
    localparam logic [7:0]  Y_LIMIT   = 8'(HEIGHT);
    localparam logic [13:0] LAST_ADDR = 14'(STRIDE * HEIGHT - 1);

    localparam logic [1:0] OP_XOR   = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;
    localparam logic [1:0] OP_READ  = 2'b11;

    typedef enum logic [2:0] {S_IDLE, S_RD, S_MOD, S_WR, S_CLR} state_t;

    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [1:0]  pix_q, pix_d;
    logic [1:0]  color_q, color_d;
    logic [13:0] mem_address_q, mem_address_d;
    logic [7:0]  mem_wdata_q, mem_wdata_d;
    logic        mem_we_q, mem_we_d;

    logic        accept;
    logic        clipped;
    logic [13:0] pix_addr;
    logic [2:0]  shamt;
    logic [7:0]  field_mask;
    logic [7:0]  color_field;

    assign accept      = bus.cmd_valid && (state_q == S_IDLE);
    assign clipped     = (bus.cmd_x >= X_LIMIT) || (bus.cmd_y >= Y_LIMIT);
    // y*80 built from shifts so no multiplier is inferred
    assign pix_addr    = {bus.cmd_y, 6'b0} + {2'b0, bus.cmd_y, 4'b0} + {7'b0, bus.cmd_x[8:2]};
    assign shamt       = {pix_q, 1'b0};
    assign field_mask  = 8'h03 << shamt;
    assign color_field = {6'b0, color_q} << shamt;

`ifdef VRAM_PLOTTER_READBACK_EN
    logic [1:0] rd_data_q, rd_data_d;
    logic       rd_valid_q, rd_valid_d;
    logic [1:0] rd_pixel;

    always_comb begin
        case (pix_q)
            2'd0:    rd_pixel = bus.mem_rdata[1:0];
            2'd1:    rd_pixel = bus.mem_rdata[3:2];
            2'd2:    rd_pixel = bus.mem_rdata[5:4];
            default: rd_pixel = bus.mem_rdata[7:6];
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_data_q  <= 2'b00;
            rd_valid_q <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
`else
    assign bus.rd_data  = 2'b00;
    assign bus.rd_valid = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        pix_d         = pix_q;
        color_d       = color_q;
        mem_address_d = mem_address_q;
        mem_wdata_d   = mem_wdata_q;
        mem_we_d      = 1'b0;
`ifdef VRAM_PLOTTER_READBACK_EN
        rd_data_d     = rd_data_q;
        rd_valid_d    = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d    = bus.cmd_op;
                    pix_d   = bus.cmd_x[1:0];
                    color_d = bus.cmd_color;
                    case (bus.cmd_op)
                        OP_CLEAR: begin
                            state_d       = S_CLR;
                            mem_address_d = 14'd0;
                            mem_wdata_d   = {4{bus.cmd_color}};
                            mem_we_d      = 1'b1;
                        end
                        OP_READ: begin
`ifdef VRAM_PLOTTER_READBACK_EN
                            if (clipped) begin
                                rd_valid_d = 1'b1;
                                rd_data_d  = 2'b00;
                            end else begin
                                state_d       = S_RD;
                                mem_address_d = pix_addr;
                            end
`else
                            state_d = S_IDLE;
`endif
                        end
                        default: begin
                            if (!clipped) begin
                                state_d       = S_RD;
                                mem_address_d = pix_addr;
                            end
                        end
                    endcase
                end
            end
            S_RD: state_d = S_MOD;
            S_MOD: begin
`ifdef VRAM_PLOTTER_READBACK_EN
                if (op_q == OP_READ) begin
                    rd_valid_d = 1'b1;
                    rd_data_d  = rd_pixel;
                    state_d    = S_IDLE;
                end else
`endif
                begin
                    if (op_q == OP_XOR)
                        mem_wdata_d = bus.mem_rdata ^ color_field;
                    else
                        mem_wdata_d = (bus.mem_rdata & ~field_mask) | color_field;
                    mem_we_d = 1'b1;
                    state_d  = S_WR;
                end
            end
            S_WR: state_d = S_IDLE;
            S_CLR: begin
                if (mem_address_q == LAST_ADDR) begin
                    state_d = S_IDLE;
                end else begin
                    mem_address_d = mem_address_q + 14'd1;
                    mem_we_d      = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_IDLE;
            op_q          <= 2'b00;
            pix_q         <= 2'b00;
            color_q       <= 2'b00;
            mem_address_q <= 14'd0;
            mem_wdata_q   <= 8'h00;
            mem_we_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            pix_q         <= pix_d;
            color_q       <= color_d;
            mem_address_q <= mem_address_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_we_q      <= mem_we_d;
        end
    end

    assign bus.cmd_ready   = (state_q == S_IDLE);
    assign bus.mem_address = mem_address_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.mem_we      = mem_we_q;

endmodule

// File: tb/tb_vram_plotter.sv
// Bench for vram_plotter: vector table, clear and reset-abort sequences, then random
// commands checked against a pixel-grid model of the screen.
module tb_vram_plotter;

    localparam int NBYTES = 16000;
    localparam logic [1:0] OP_PLOT  = 2'b00;
    localparam logic [1:0] OP_XOR   = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;
    localparam logic [1:0] OP_READ  = 2'b11;
`ifdef VRAM_PLOTTER_READBACK_EN
    localparam int RB = 1;
`else
    localparam int RB = 0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    vram_plotter_if bus ();

    vram_plotter dut (.clock(clock), .reset(reset), .bus(bus));

    always #5 clock = ~clock;

    logic [7:0]  ram [NBYTES];
    logic [7:0]  rdata_r = 8'h00;
    logic        pre_en = 1'b0;
    int          pre_addr = 0;
    logic [7:0]  pre_val = 8'h00;
    int          cyc = 0, we_total = 0, we_rise = 0, addr_jumps = 0, wdata_changes = 0;
    int          rd_total = 0, bad_we_addr = 0, last_we_cyc = 0;
    logic        prev_we = 1'b0;
    logic [13:0] prev_addr = '0, last_addr = '0, rise_addr = '0;
    logic [7:0]  prev_wdata = '0, last_wdata = '0;
    logic [1:0]  last_rd = '0;

    assign bus.mem_rdata = rdata_r;

    // RAM with one-cycle read latency plus a write/readback monitor
    always @(posedge clock) begin
        if (int'(bus.mem_address) < NBYTES) rdata_r <= ram[bus.mem_address];
        else rdata_r <= 8'h00;
        if (pre_en) ram[pre_addr] <= pre_val;
        if (bus.mem_we) begin
            if (int'(bus.mem_address) < NBYTES) ram[bus.mem_address] <= bus.mem_wdata;
            else bad_we_addr++;
            we_total++;
            if (!prev_we) begin
                we_rise++;
                rise_addr = bus.mem_address;
            end else begin
                if (bus.mem_address != prev_addr + 14'd1) addr_jumps++;
                if (bus.mem_wdata != prev_wdata) wdata_changes++;
            end
            last_we_cyc = cyc;
            last_addr   = bus.mem_address;
            last_wdata  = bus.mem_wdata;
        end
        if (bus.rd_valid) begin
            rd_total++;
            last_rd = bus.rd_data;
        end
        prev_we    = bus.mem_we;
        prev_addr  = bus.mem_address;
        prev_wdata = bus.mem_wdata;
        cyc++;
    end

    int checks = 0;
    int passes = 0;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual == expected) passes++;
        else $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, actual, actual, expected, expected);
    endtask

    task automatic applyStimulus(input logic [1:0] op, input int x, input int y, input logic [1:0] color,
                                 input bit preload, input logic [7:0] seed, output int acc_cyc);
        int guard = 0;
        while (!bus.cmd_ready && guard < 20000) begin
            @(negedge clock);
            guard++;
        end
        checkOutput("ready_before_cmd", bus.cmd_ready, 1);
        bus.cmd_op    = op;
        bus.cmd_x     = 9'(x);
        bus.cmd_y     = 8'(y);
        bus.cmd_color = color;
        bus.cmd_valid = 1'b1;
        pre_en        = preload;
        pre_addr      = y * 80 + x / 4;
        pre_val       = seed;
        @(negedge clock);
        bus.cmd_valid = 1'b0;
        pre_en        = 1'b0;
        acc_cyc       = cyc - 1;
    endtask

    task automatic waitIdle(input int budget, output int busy);
        busy = 0;
        while (!bus.cmd_ready && busy < budget) begin
            @(negedge clock);
            busy++;
        end
    endtask

    logic [1:0] ref_pix [200][320];

    function automatic logic [7:0] ref_byte(input int y, input int xb);
        logic [7:0] b = 8'h00;
        for (int k = 0; k < 4; k++) b = b | (8'(ref_pix[y][xb * 4 + k]) << (2 * k));
        return b;
    endfunction

    typedef struct {
        logic [1:0] op;
        int         x;
        int         y;
        logic [1:0] color;
        logic [7:0] seed_byte;
        int         exp_busy;
        int         exp_writes;
        int         exp_addr;
        logic [7:0] exp_wdata;
        int         exp_reads;
        logic [1:0] exp_rd;
    } vec_t;

    vec_t vecs [9];

    initial begin
        int acc, busy, w0, r0, rise0, j0, c0;
        bit in_range;

        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_x     = '0;
        bus.cmd_y     = '0;
        bus.cmd_color = '0;

        vecs[0] = '{OP_PLOT,   0,   0, 2'd3, 8'h00, 3, 1,     0, 8'h03, 0, 2'd0};
        vecs[1] = '{OP_PLOT,   7,   1, 2'd2, 8'hFF, 3, 1,    81, 8'hBF, 0, 2'd0};
        vecs[2] = '{OP_XOR,  319, 199, 2'd1, 8'hC0, 3, 1, 15999, 8'h80, 0, 2'd0};
        vecs[3] = '{OP_PLOT, 320,   5, 2'd1, 8'h00, 0, 0,     0, 8'h00, 0, 2'd0};
        vecs[4] = '{OP_PLOT,   0, 200, 2'd1, 8'h00, 0, 0,     0, 8'h00, 0, 2'd0};
        vecs[5] = '{OP_XOR,    2,   3, 2'd3, 8'h30, 3, 1,   240, 8'h00, 0, 2'd0};
        vecs[6] = '{OP_PLOT,   5,  10, 2'd0, 8'hFF, 3, 1,   801, 8'hF3, 0, 2'd0};
        vecs[7] = '{OP_READ,   6,   0, 2'd0, 8'h20, 2 * RB, 0, 0, 8'h00, RB, 2'd2};
        vecs[8] = '{OP_READ, 400,   0, 2'd0, 8'h00, 0, 0,     0, 8'h00, RB, 2'd0};

        repeat (3) @(negedge clock);
        checkOutput("reset_cmd_ready", bus.cmd_ready, 1);
        checkOutput("reset_mem_we", bus.mem_we, 0);
        checkOutput("reset_mem_address", bus.mem_address, 0);
        checkOutput("reset_mem_wdata", bus.mem_wdata, 0);
        checkOutput("reset_rd_valid", bus.rd_valid, 0);
        checkOutput("reset_rd_data", bus.rd_data, 0);
        reset = 1'b0;
        @(negedge clock);

        for (int i = 0; i < 9; i++) begin
            w0 = we_total; r0 = rd_total; rise0 = we_rise;
            in_range = (vecs[i].x < 320) && (vecs[i].y < 200);
            applyStimulus(vecs[i].op, vecs[i].x, vecs[i].y, vecs[i].color, in_range, vecs[i].seed_byte, acc);
            waitIdle(50, busy);
            @(negedge clock);
            $display("[TB] vector %0d op=%0d x=%0d y=%0d", i, vecs[i].op, vecs[i].x, vecs[i].y);
            checkOutput("vec_busy", busy, vecs[i].exp_busy);
            checkOutput("vec_writes", we_total - w0, vecs[i].exp_writes);
            checkOutput("vec_reads", rd_total - r0, vecs[i].exp_reads);
            if (vecs[i].exp_writes != 0) begin
                checkOutput("vec_we_runs", we_rise - rise0, 1);
                checkOutput("vec_addr", last_addr, vecs[i].exp_addr);
                checkOutput("vec_wdata", last_wdata, vecs[i].exp_wdata);
                checkOutput("vec_we_latency", last_we_cyc - acc, 3);
            end
            if (vecs[i].exp_reads != 0) checkOutput("vec_rd_data", last_rd, vecs[i].exp_rd);
        end

        // full clear with colour 1
        w0 = we_total; rise0 = we_rise; j0 = addr_jumps; c0 = wdata_changes;
        applyStimulus(OP_CLEAR, 0, 0, 2'd1, 1'b0, 8'h00, acc);
        waitIdle(20000, busy);
        @(negedge clock);
        checkOutput("clr_busy", busy, 16000);
        checkOutput("clr_writes", we_total - w0, 16000);
        checkOutput("clr_runs", we_rise - rise0, 1);
        checkOutput("clr_addr_jumps", addr_jumps - j0, 0);
        checkOutput("clr_wdata_changes", wdata_changes - c0, 0);
        checkOutput("clr_first_addr", rise_addr, 0);
        checkOutput("clr_last_addr", last_addr, 15999);
        checkOutput("clr_wdata", last_wdata, 8'h55);
        checkOutput("clr_span", last_we_cyc - acc, 16000);
        checkOutput("clr_ready_after", bus.cmd_ready, 1);

        // reset during a second clear
        w0 = we_total;
        applyStimulus(OP_CLEAR, 0, 0, 2'd2, 1'b0, 8'h00, acc);
        busy = 0;
        while (we_total - w0 < 100 && busy < 200) begin
            @(negedge clock);
            busy++;
        end
        checkOutput("abort_reached_100", (we_total - w0 >= 100) ? 1 : 0, 1);
        reset = 1'b1;
        @(negedge clock);
        checkOutput("abort_mem_we", bus.mem_we, 0);
        checkOutput("abort_cmd_ready", bus.cmd_ready, 1);
        reset = 1'b0;
        w0 = we_total;
        repeat (20) @(negedge clock);
        checkOutput("abort_no_resume", we_total - w0, 0);
        checkOutput("abort_ready_stays", bus.cmd_ready, 1);

        // blank the screen so the RAM matches an all-zero model
        applyStimulus(OP_CLEAR, 0, 0, 2'd0, 1'b0, 8'h00, acc);
        waitIdle(20000, busy);
        @(negedge clock);
        checkOutput("blank_busy", busy, 16000);
        checkOutput("bad_we_addr", bad_we_addr, 0);
        for (int yy = 0; yy < 200; yy++)
            for (int xx = 0; xx < 320; xx++) ref_pix[yy][xx] = 2'd0;

        for (int n = 0; n < 300; n++) begin
            logic [1:0] op, color;
            int x, y, exp_busy, exp_w, exp_r;
            logic [1:0] exp_rd;
            case ($urandom_range(0, 2))
                0:       op = OP_PLOT;
                1:       op = OP_XOR;
                default: op = OP_READ;
            endcase
            x = int'($urandom_range(0, 339));
            y = int'($urandom_range(0, 209));
            color = 2'($urandom_range(0, 3));
            in_range = (x < 320) && (y < 200);
            exp_rd = 2'd0;
            if (in_range) begin
                exp_rd = ref_pix[y][x];
                if (op == OP_PLOT) ref_pix[y][x] = color;
                if (op == OP_XOR)  ref_pix[y][x] = ref_pix[y][x] ^ color;
            end
            exp_w    = (op != OP_READ && in_range) ? 1 : 0;
            exp_r    = (op == OP_READ) ? RB : 0;
            exp_busy = exp_w ? 3 : ((op == OP_READ && in_range) ? 2 * RB : 0);

            w0 = we_total; r0 = rd_total;
            applyStimulus(op, x, y, color, 1'b0, 8'h00, acc);
            waitIdle(50, busy);
            @(negedge clock);
            checkOutput("rnd_busy", busy, exp_busy);
            checkOutput("rnd_writes", we_total - w0, exp_w);
            checkOutput("rnd_reads", rd_total - r0, exp_r);
            if (exp_w != 0) checkOutput("rnd_byte", ram[y * 80 + x / 4], ref_byte(y, x / 4));
            if (exp_r != 0) checkOutput("rnd_rd_data", last_rd, exp_rd);
        end

        checkOutput("final_bad_we_addr", bad_we_addr, 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/vram_plotter.md
Name: vram_plotter

Overview:
- Write-side master for the 16 KB, 2-bpp packed framebuffer that the video scan-out block reads.
- Accepts pixel commands through a valid/ready handshake. Supported commands are plot, xor-plot, full-screen clear and, optionally, pixel readback.
- Plot and xor-plot are done as read-modify-write on the byte that holds the target pixel. Clear streams byte writes.
- Sits between the CPU/IO decode and the framebuffer RAM's write port.

Parameters:
WIDTH, 320, logical pixels per row
HEIGHT, 200, logical rows
STRIDE, 80, bytes per row (WIDTH/4)

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high
cmd_valid  input  1  command present
cmd_ready  output  1  block can accept a command (high only in IDLE)
cmd_op  input  2  00 plot, 01 xor-plot, 10 clear, 11 read (optional feature)
cmd_x  input  9  pixel column
cmd_y  input  8  pixel row
cmd_color  input  2  colour index
mem_address  output  14  framebuffer byte address
mem_rdata  input  8  RAM read data, valid the cycle after mem_address is presented
mem_wdata  output  8  write data
mem_we  output  1  write strobe, one byte per cycle while high
rd_data  output  2  readback pixel (optional feature)
rd_valid  output  1  one-cycle pulse with rd_data (optional feature)

Behaviour:
- Reset values:
  - state IDLE; cmd_ready 1 (it is a pure decode of IDLE); mem_we 0; mem_address 0; mem_wdata 0; rd_valid 0; rd_data 0.
  - Reset mid-operation aborts at the next edge: mem_we low, no partial write, an interrupted clear is not resumed.
- Layout:
  - addr = y*80 + x[8:2], computed as (y<<6)+(y<<4)+x[8:2] in 14 bits. Maximum is 15999.
  - Pixel k = x[1:0] occupies byte bits [2k+1:2k], so x[1:0]=0 is bits [1:0] and x[1:0]=3 is bits [7:6].
- Handshake:
  - A command is accepted on an edge where cmd_valid && cmd_ready.
  - cmd_x, cmd_y, cmd_color and cmd_op are latched at acceptance.
- Clipping:
  - For plot, xor-plot and read, x>=WIDTH or y>=HEIGHT means the command is accepted and dropped.
  - A dropped command makes no memory access and the block stays in IDLE.
- FSM IDLE->RD->MOD->WR->IDLE (plot/xor):
  - Accept edge E0: mem_address <= addr; go to RD.
  - E1: go to MOD. mem_rdata is valid during MOD.
  - E2, plot: mem_wdata <= rdata with the 2-bit field replaced by color.
  - E2, xor: mem_wdata <= rdata ^ (color << 2k).
  - E2 (both): mem_we <= 1; go to WR.
  - E3: mem_we <= 0; go to IDLE.
  - cmd_ready is low for the 3 cycles RD, MOD, WR. Next accept is possible at E4.
- Clear:
  - E0: go to CLR with mem_address <= 0, mem_wdata <= {4{color}}, mem_we <= 1.
  - Address increments each cycle. After the write to address 15999, mem_we <= 0 and state returns to IDLE.
  - Exactly 16000 write cycles, no read. Colour is fixed at acceptance.
- mem_we is never high outside WR and CLR. mem_address holds its last value when idle.
- cmd_valid is ignored while cmd_ready is low; there is no command queue.

Optional Feature:
- Macro VRAM_PLOTTER_READBACK_EN.
- Defined:
  - op 11 uses RD->MOD.
  - At the MOD edge, rd_data <= rdata[2k+1:2k] and rd_valid <= 1 for one cycle; then IDLE with no write.
  - Busy 2 cycles.
  - A clipped read gives rd_valid 1 and rd_data 0 on the cycle after acceptance.
- Undefined:
  - op 11 is accepted and dropped as a NOP.
  - rd_data and rd_valid are tied to 0.

Test Plan:
- plot x=0,y=0,color=3, mem_rdata=00 -> exactly one mem_we cycle, address 0, wdata 03, mem_we high 3 cycles after accept, cmd_ready back the following cycle.
- plot x=7,y=1,color=2, rdata=FF -> address 81, wdata BF.
- xor x=319,y=199,color=1, rdata=C0 -> address 15999, wdata 80.
- plot x=320,y=5 and plot x=0,y=200 -> both accepted, mem_we never asserted, cmd_ready stays high.
- clear color=1 -> 16000 consecutive mem_we cycles, addresses 0..15999 in order, wdata 55; cmd_ready low throughout, high the cycle after. Assert reset at write 100 of a second clear -> mem_we 0 the next cycle, cmd_ready 1.
- With VRAM_PLOTTER_READBACK_EN: read x=6,y=0, rdata=20 -> rd_valid single pulse, rd_data 2, no mem_we. Without the macro the same command -> no memory access, rd_valid 0.
